// File: rtl/simple_channel_arbiter.sv
// simple_channel_arbiter
//   Round-robin arbiter that lets NREQ requesters share one simple-style
//   register channel, one transaction at a time. Each transaction issues the
//   winner's write word with a one-cycle strobe, waits (bounded) for the
//   responder's word and hands it back to the winner with a done pulse.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req             per-requester request, held until the matching done
//   wdata           per-requester write words, requester i at [i*WIDTH +: WIDTH]
//   gnt             one-hot grant, high from ISSUE through RESP
//   done            one-hot one-cycle completion pulse
//   rdata           response word, valid with done
//   timeout_err     set with done when no response arrived in time
//   simple1         channel write word (holds last captured winner data)
//   simple1_valid   one-cycle issue strobe
//   simple2         channel response word
//   simple2_valid   response strobe
//
// state | meaning
// IDLE  | waiting for any request; picks winner from rr pointer upward
// ISSUE | strobe simple1 for the winner; responses ignored
// WAIT  | waiting for simple2_valid, bounded by TIMEOUT cycles
// RESP  | done pulse to winner; rr pointer advances past winner
module simple_channel_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      rdata,
  output logic                  timeout_err,
  output logic [WIDTH-1:0]      simple1,
  output logic                  simple1_valid,
  input  logic [WIDTH-1:0]      simple2,
  input  logic                  simple2_valid
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] simple1_q, simple1_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             terr_q, terr_d;

  logic             sel_found;
  logic [PW-1:0]    sel_idx;
  logic [WIDTH-1:0] sel_word;
  int               scan_idx;
  logic [PW-1:0]    scan_sel;
  logic [NREQ-1:0]  win_oh;

  // First set request bit scanning upward from the rr pointer, with wrap.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = 0;
    scan_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = int'(ptr_q) + i;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      scan_sel = PW'(scan_idx);
      if (!sel_found && req[scan_sel]) begin
        sel_found = 1'b1;
        sel_idx   = scan_sel;
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_idx == PW'(i)) sel_word = wdata[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    simple1_d = simple1_q;
    rdata_d   = rdata_q;
    terr_d    = terr_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          win_d     = sel_idx;
          simple1_d = sel_word;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A response in the final counted cycle still wins over the timeout.
        if (simple2_valid) begin
          rdata_d = simple2;
          terr_d  = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          terr_d  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
        rdata_d = '0;
        terr_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      simple1_q <= '0;
      rdata_q   <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      simple1_q <= simple1_d;
      rdata_q   <= rdata_d;
      terr_q    <= terr_d;
    end
  end

  assign win_oh        = NREQ'(1) << win_q;
  assign gnt           = (state_q != IDLE) ? win_oh : '0;
  assign done          = (state_q == RESP) ? win_oh : '0;
  assign simple1_valid = (state_q == ISSUE);
  assign simple1       = simple1_q;
  assign rdata         = rdata_q;
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_simple_channel_arbiter.sv
// Testbench for simple_channel_arbiter: scoreboard of expected completions
// (winner, response word, timeout flag) pushed when a request is driven and
// popped when done is observed. A background responder answers each issue
// strobe after a programmable number of cycles.
module tb_simple_channel_arbiter;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 15;
  localparam logic [31:0] MASK = 32'h5A5A_F00F;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] wdata = '0;
  logic [NREQ-1:0]       gnt, done;
  logic [WIDTH-1:0]      rdata, simple1, simple2;
  logic                  timeout_err, simple1_valid, simple2_valid;

  always #5 clk = ~clk;

  simple_channel_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt), .done(done),
    .rdata(rdata), .timeout_err(timeout_err), .simple1(simple1),
    .simple1_valid(simple1_valid), .simple2(simple2), .simple2_valid(simple2_valid)
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          mdl_ptr = 0;
  int          resp_delay = -1;
  logic        resp_fixed_en = 1'b0;
  logic [31:0] resp_fixed = '0;

  // Responder: answers resp_delay negedges after the issue strobe is seen
  // (0 = during the ISSUE cycle itself, -1 = never).
  initial begin
    int  cnt;
    bit  armed;
    cnt = 0;
    armed = 0;
    simple2_valid = 1'b0;
    simple2 = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      simple2_valid = 1'b0;
      if (armed) cnt++;
      if (simple1_valid === 1'b1 && resp_delay >= 0) begin
        armed = 1;
        cnt = 0;
      end
      if (armed && cnt == resp_delay) begin
        simple2_valid = 1'b1;
        simple2 = resp_fixed_en ? resp_fixed : (simple1 ^ MASK);
        armed = 0;
      end
    end
  end

  function automatic logic [31:0] word_of(input int i);
    return wdata[i*WIDTH +: WIDTH];
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    int w;
    w = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (w < 0 && r[(p + i) % NREQ]) w = (p + i) % NREQ;
    end
    return w;
  endfunction

  task automatic wait_strobe(input int budget, output int n);
    n = 0;
    while (n < budget && simple1_valid !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    if (simple1_valid !== 1'b1) n = -1;
  endtask

  task automatic wait_done(input int budget, output int n);
    bit seen;
    seen = 0;
    n = 0;
    while (n < budget && !seen) begin
      @(negedge clk);
      n++;
      if (done !== '0) seen = 1;
    end
    if (!seen) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    checks++; if (done !== '0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
    checks++; if (simple1 !== '0) begin errors++; $display("FAIL reset_simple1: got %h want 0", simple1); end
    checks++; if (simple1_valid !== 1'b0) begin errors++; $display("FAIL reset_s1v: got %b want 0", simple1_valid); end
    rst = 1'b0;
    mdl_ptr = 0;
  endtask

  task automatic test_single();
    int   n;
    exp_t e;
    wdata[0 +: WIDTH] = 32'h0000_55AA;
    resp_fixed_en = 1'b1;
    resp_fixed = 32'h1234_5678;
    resp_delay = 2;
    req = 4'b0001;
    e.idx = 0; e.data = 32'h1234_5678; e.err = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    checks++; if (simple1_valid !== 1'b1) begin errors++; $display("FAIL single_strobe: got %b want 1", simple1_valid); end
    checks++; if (simple1 !== 32'h0000_55AA) begin errors++; $display("FAIL single_simple1: got %h want 000055aa", simple1); end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt_issue: got %b want 0001", gnt); end
    @(negedge clk);
    checks++; if (simple1_valid !== 1'b0) begin errors++; $display("FAIL single_strobe_len: got %b want 0", simple1_valid); end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt_wait: got %b want 0001", gnt); end
    req = 4'b0000;
    wait_done(20, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL single_latency: got %0d want 2", n); end
    if (exp_q.size() == 0) begin
      checks++; errors++; $display("FAIL single_sb: got empty scoreboard want entry");
    end else begin
      e = exp_q.pop_front();
      checks++; if (done !== (4'b0001 << e.idx)) begin errors++; $display("FAIL single_done: got %b want idx %0d", done, e.idx); end
      checks++; if (rdata !== e.data) begin errors++; $display("FAIL single_rdata: got %h want %h", rdata, e.data); end
      checks++; if (timeout_err !== e.err) begin errors++; $display("FAIL single_terr: got %b want %b", timeout_err, e.err); end
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt_resp: got %b want 0001", gnt); end
      mdl_ptr = (e.idx + 1) % NREQ;
    end
    @(negedge clk);
    checks++; if ({gnt, done, rdata, timeout_err} !== '0) begin errors++; $display("FAIL single_after: got gnt=%b done=%b rdata=%h terr=%b want all 0", gnt, done, rdata, timeout_err); end
    checks++; if (simple1 !== 32'h0000_55AA) begin errors++; $display("FAIL single_s1_hold: got %h want 000055aa", simple1); end
    resp_fixed_en = 1'b0;
  endtask

  task automatic test_round_robin();
    int   n, p, w;
    exp_t e;
    resp_delay = 1;
    resp_fixed_en = 1'b0;
    for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = 32'hA0B0_0000 + 32'(i) * 32'h1111;
    req = 4'b1111;
    p = mdl_ptr;
    for (int k = 0; k < 5; k++) begin
      w = pick(req, p);
      e.idx = w; e.data = word_of(w) ^ MASK; e.err = 1'b0;
      exp_q.push_back(e);
      p = (w + 1) % NREQ;
    end
    mdl_ptr = p;
    for (int k = 0; k < 5; k++) begin
      wait_done(20, n);
      if (k == 4) req = 4'b0000;
      checks++; if (n !== ((k == 0) ? 3 : 4)) begin errors++; $display("FAIL rr_spacing%0d: got %0d want %0d", k, n, (k == 0) ? 3 : 4); end
      if (exp_q.size() == 0) begin
        checks++; errors++; $display("FAIL rr_sb%0d: got empty scoreboard want entry", k);
      end else begin
        e = exp_q.pop_front();
        checks++; if (done !== (4'b0001 << e.idx)) begin errors++; $display("FAIL rr_done%0d: got %b want idx %0d", k, done, e.idx); end
        checks++; if (rdata !== e.data || timeout_err !== e.err) begin errors++; $display("FAIL rr_data%0d: got %h/%b want %h/%b", k, rdata, timeout_err, e.data, e.err); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_pointer_skip();
    int   n;
    exp_t e;
    resp_delay = 1;
    req = 4'b0100;
    e.idx = 2; e.data = word_of(2) ^ MASK; e.err = 1'b0; exp_q.push_back(e);
    e.idx = 0; e.data = word_of(0) ^ MASK; exp_q.push_back(e);
    e.idx = 2; e.data = word_of(2) ^ MASK; exp_q.push_back(e);
    for (int k = 0; k < 3; k++) begin
      wait_done(20, n);
      if (k == 0) req = 4'b0101;
      if (k == 2) req = 4'b0000;
      if (n < 0 || exp_q.size() == 0) begin
        checks++; errors++; $display("FAIL skip_wait%0d: got no done (n=%0d) want done", k, n);
      end else begin
        e = exp_q.pop_front();
        checks++; if (done !== (4'b0001 << e.idx)) begin errors++; $display("FAIL skip_done%0d: got %b want idx %0d", k, done, e.idx); end
        checks++; if (rdata !== e.data) begin errors++; $display("FAIL skip_rdata%0d: got %h want %h", k, rdata, e.data); end
      end
    end
    mdl_ptr = 3;
    @(negedge clk);
  endtask

  task automatic test_timeout(input int delay, input logic [NREQ-1:0] r, input int w,
                              input logic expect_err);
    int   n;
    exp_t e;
    resp_delay = delay;
    resp_fixed_en = 1'b1;
    resp_fixed = 32'hCAFE_0000 | 32'(delay & 255);
    req = r;
    e.idx = w; e.err = expect_err;
    e.data = expect_err ? 32'h0 : resp_fixed;
    exp_q.push_back(e);
    wait_strobe(10, n);
    req = '0;
    checks++; if (n < 0) begin errors++; $display("FAIL to_strobe_d%0d: got no strobe want strobe", delay); end
    wait_done(40, n);
    checks++; if (n !== TIMEOUT + 1) begin errors++; $display("FAIL to_latency_d%0d: got %0d want %0d", delay, n, TIMEOUT + 1); end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++; if (done !== (4'b0001 << e.idx)) begin errors++; $display("FAIL to_done_d%0d: got %b want idx %0d", delay, done, e.idx); end
      checks++; if (timeout_err !== e.err) begin errors++; $display("FAIL to_terr_d%0d: got %b want %b", delay, timeout_err, e.err); end
      checks++; if (rdata !== e.data) begin errors++; $display("FAIL to_rdata_d%0d: got %h want %h", delay, rdata, e.data); end
    end
    mdl_ptr = (w + 1) % NREQ;
    resp_fixed_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid(input logic [NREQ-1:0] req_a, input int win_a,
                                input logic [NREQ-1:0] req_b, input int win_b);
    int   n;
    bit   saw_done;
    exp_t e;
    resp_delay = -1;
    resp_fixed_en = 1'b0;
    req = req_a;
    wait_strobe(10, n);
    checks++; if (gnt !== (4'b0001 << win_a)) begin errors++; $display("FAIL rmid_gnt_a%0d: got %b want idx %0d", win_a, gnt, win_a); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({gnt, done, simple1_valid, simple1, rdata, timeout_err} !== '0) begin
      errors++; $display("FAIL rmid_async%0d: got gnt=%b done=%b s1v=%b s1=%h rdata=%h terr=%b want all 0",
                         win_a, gnt, done, simple1_valid, simple1, rdata, timeout_err);
    end
    saw_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (done !== '0) saw_done = 1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL rmid_nodone%0d: got done pulse want none", win_a); end
    rst = 1'b0;
    req = req_b;
    resp_delay = 1;
    e.idx = win_b; e.data = word_of(win_b) ^ MASK; e.err = 1'b0;
    exp_q.push_back(e);
    wait_done(20, n);
    req = '0;
    checks++; if (n !== 3) begin errors++; $display("FAIL rmid_latency%0d: got %0d want 3", win_b, n); end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++; if (done !== (4'b0001 << e.idx)) begin errors++; $display("FAIL rmid_done_b%0d: got %b want idx %0d", win_b, done, e.idx); end
      checks++; if (rdata !== e.data) begin errors++; $display("FAIL rmid_rdata_b%0d: got %h want %h", win_b, rdata, e.data); end
    end
    mdl_ptr = (win_b + 1) % NREQ;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_skip();
    test_timeout(-1, 4'b1000, 3, 1'b1);
    test_timeout(TIMEOUT, 4'b0001, 0, 1'b0);
    test_timeout(0, 4'b0010, 1, 1'b1);
    test_reset_mid(4'b0100, 2, 4'b0100, 2);
    test_reset_mid(4'b1000, 3, 4'b1001, 0);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/simple_channel_arbiter.md
Name: simple_channel_arbiter

Overview:
- Shares one `simple`-style register channel among NREQ requesters.
- Round-robin arbitration, one transaction at a time.
- Each transaction:
  - drives the winner's write word onto simple1 with a one-cycle valid strobe;
  - waits for the responder's simple2 word (bounded by a timeout);
  - returns that word to the winner with a done pulse.
- Sits between the submodules that own the dir1 side of a shared channel and the single physical channel instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, channel data width; matches the interface WIDTH
- TIMEOUT, 15, maximum WAIT cycles before the transaction is aborted with an error (1..255)

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  NREQ  per-requester request; must be held until the matching done
- wdata  input  NREQ*WIDTH  per-requester write word; requester i uses bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot grant; high from ISSUE through RESP inclusive
- done  output  NREQ  one-hot, one-cycle completion pulse
- rdata  output  WIDTH  response word; valid while done is high
- timeout_err  output  1  high with done when the transaction timed out
- simple1  output  WIDTH  channel write word; holds the captured winner data
- simple1_valid  output  1  one-cycle issue strobe
- simple2  input  WIDTH  channel response word
- simple2_valid  input  1  response strobe

Behaviour:
- Reset state:
  - state IDLE; rr pointer = 0; wait counter = 0.
  - gnt, done, rdata, timeout_err, simple1, simple1_valid all 0.
  - Reset asserted mid-transaction aborts immediately: no done pulse; pointer returns to 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req != 0, select the first set bit scanning upward from the rr pointer, wrapping modulo NREQ.
  - Capture the winner index and its wdata into simple1; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - gnt[winner]=1 and simple1_valid=1.
  - simple2_valid is ignored in this cycle.
  - Clear the wait counter; go to WAIT.
- WAIT:
  - If simple2_valid: capture simple2 into rdata, clear timeout_err, go to RESP.
  - Else if counter == TIMEOUT-1: rdata=0, timeout_err=1, go to RESP.
  - Else increment the counter.
  - If simple2_valid arrives in the final timeout cycle, valid wins and timeout_err stays 0.
- RESP (1 cycle):
  - done[winner]=1; rdata and timeout_err valid.
  - rr pointer = (winner+1) mod NREQ.
  - Next state IDLE; gnt, timeout_err and rdata clear on leaving RESP.
- Latency:
  - req sampled in IDLE at cycle 0 → ISSUE at cycle 1 → WAIT from cycle 2.
  - simple2_valid at cycle k ≥ 2 gives done at k+1; minimum req-to-done is 3 cycles.
  - Back-to-back transactions have a minimum spacing of 4 cycles (RESP→IDLE→ISSUE).
- simple1 holds its value after ISSUE until the next capture; it is not cleared on RESP.
- A requester dropping req mid-transaction does not abort it; done is still pulsed.
- req changes outside IDLE have no effect on the current winner.
- Pointer wrap: winner NREQ-1 sets the pointer to 0.
- Counter width is $clog2(TIMEOUT+1); no overflow is possible.

Test Plan:
- Single request:
  - Stimulus: req=0001, wdata[0]=0x000055AA; responder asserts simple2_valid with simple2=0x12345678 two cycles after simple1_valid.
  - Required: simple1=0x55AA with a one-cycle strobe; done=0001 with rdata=0x12345678 and timeout_err=0; gnt=0001 for ISSUE..RESP.
- Round-robin:
  - Stimulus: req=1111 held continuously with an immediate responder.
  - Required: grants in order 0,1,2,3,0; each done one-hot; no requester granted twice before all others are served.
- Pointer skip:
  - Stimulus: after requester 2 completes, req=0101.
  - Required: the next grant is requester 0 (wrap past 3); the following grant is requester 2.
- Timeout:
  - Stimulus: TIMEOUT=15, no simple2_valid.
  - Required: done exactly 15 WAIT cycles after ISSUE, with timeout_err=1 and rdata=0.
  - Repeat with simple2_valid on WAIT cycle 15: timeout_err=0 and rdata = captured simple2.
- Ignored early response:
  - Stimulus: simple2_valid asserted in the ISSUE cycle only.
  - Required: no capture; the transaction times out.
- Reset mid-WAIT:
  - Stimulus: assert rst asynchronously during WAIT for requester 2.
  - Required: all outputs 0 immediately with no done pulse; after release with req=0100, the pointer restarts at 0 and requester 2 is granted.
